// File: rtl/tetris_vga_pkg.sv
// Shared constants and types for the Tetris VGA pixel path.
// Timing offsets, board geometry, color codes, FSM and region enums.
package tetris_vga_pkg;

  localparam int TFP_H   = 224;
  localparam int TFP_V   = 12;
  localparam int TSYNC_H = 1600;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int CELL_PX    = 16;

  localparam logic [2:0] CLR_BLACK = 3'b000;
  localparam logic [2:0] CLR_BLUE  = 3'b001;
  localparam logic [2:0] CLR_GREEN = 3'b010;
  localparam logic [2:0] CLR_RED   = 3'b100;
  localparam logic [2:0] CLR_WHITE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ADDR,
    S_WAIT,
    S_BUILD,
    S_HOLD
  } fetch_state_e;

  typedef enum logic [1:0] {
    RG_BG,
    RG_FRAME,
    RG_BOARD
  } region_e;

endpackage

// File: rtl/vga_board_fetch_if.sv
// Board RAM read port: address and strobe out, cell color back.
// master = fetch unit, slave = RAM; data valid 1 cycle after rd_en.
interface vga_board_fetch_if;
  logic [7:0] ram_addr;
  logic       ram_rd_en;
  logic [2:0] ram_data;

  modport master (
    output ram_addr,
    output ram_rd_en,
    input  ram_data
  );

  modport slave (
    input  ram_addr,
    input  ram_rd_en,
    output ram_data
  );
endinterface

// File: rtl/vga_board_fetch_cell_word_builder.sv
// Turns a region, cell color and line offset into a 16-pixel word.
// Ports: region_i, color_i, yoff_i in; word_o (48 bits) out.
module cell_word_builder
  import tetris_vga_pkg::*;
#(
  parameter logic [2:0] BORDER_COLOR = 3'b111,
  parameter logic [2:0] BG_COLOR     = 3'b000
) (
  input  region_e     region_i,
  input  logic [2:0]  color_i,
  input  logic [3:0]  yoff_i,
  output logic [47:0] word_o
);

  always_comb begin
    word_o = {16{BG_COLOR}};
    unique case (region_i)
      RG_BOARD: begin
        if (color_i != CLR_BLACK) begin
          // last line and last pixel are black bevel
          if (yoff_i == 4'hF)
            word_o = '0;
          else
            word_o = {CLR_BLACK, {15{color_i}}};
        end
      end
      RG_FRAME: word_o = {16{BORDER_COLOR}};
      default:  word_o = {16{BG_COLOR}};
    endcase
  end

endmodule

// File: rtl/vga_board_fetch.sv
// Prefetches the next 16-pixel word from board RAM, piece and frame.
// Ports: clk, rst, cnt_X/cnt_Y, ram (board RAM), piece_*, pixels.
module vga_board_fetch
  import tetris_vga_pkg::*;
#(
  parameter int         BOARD_X0     = 240,
  parameter int         BOARD_Y0     = 80,
  parameter logic [2:0] BORDER_COLOR = 3'b111,
  parameter logic [2:0] BG_COLOR     = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] cnt_X,
  input  logic [9:0]  cnt_Y,
  vga_board_fetch_if.master ram,
  input  logic        piece_valid,
  input  logic [15:0] piece_x,
  input  logic [19:0] piece_y,
  input  logic [2:0]  piece_color,
  output logic [47:0] pixels
);

  localparam logic signed [11:0] SX_OFF  = 12'(TFP_H / 2);
  localparam logic signed [11:0] SY_OFF  = 12'(TFP_V);
  localparam logic signed [11:0] X0      = 12'(BOARD_X0);
  localparam logic signed [11:0] Y0      = 12'(BOARD_Y0);
  localparam logic signed [11:0] ZERO    = 12'sd0;
  localparam logic signed [11:0] NEG1    = -12'sd1;
  localparam logic signed [11:0] COL_MAX = 12'(BOARD_COLS - 1);
  localparam logic signed [11:0] ROW_MAX = 12'(BOARD_ROWS - 1);
  localparam logic signed [11:0] COL_FR  = 12'(BOARD_COLS);
  localparam logic signed [11:0] ROW_FR  = 12'(BOARD_ROWS);

  logic [4:0]         phase;
  logic [5:0]         tw;
  logic signed [11:0] sx;
  logic signed [11:0] sy;
  logic signed [11:0] dy;
  logic signed [11:0] col_c;
  logic signed [11:0] row_c;
  logic               in_board;
  logic               in_frame;
  region_e            region_c;
  logic [7:0]         addr_c;
  logic               hit;
  logic [47:0]        word_c;

  fetch_state_e state_q, state_d;
  region_e      region_q, region_d;
  logic [3:0]   col_q, col_d;
  logic [4:0]   row_q, row_d;
  logic [3:0]   yoff_q, yoff_d;
  logic [2:0]   color_q, color_d;
  logic [47:0]  staging_q, staging_d;
  logic [47:0]  pixels_q, pixels_d;
  logic [7:0]   addr_q, addr_d;
  logic         rd_en_q, rd_en_d;

  // target is the word shown after the next latch
  assign phase = cnt_X[4:0];
  assign tw    = cnt_X[10:5] + 6'd1;
  assign sx    = $signed({2'b00, tw, 4'b0000}) - SX_OFF;
  assign sy    = $signed({2'b00, cnt_Y}) - SY_OFF;
  assign dy    = sy - Y0;
  // arithmetic shift keeps -16..-1 as cell -1
  assign col_c = (sx - X0) >>> 4;
  assign row_c = dy >>> 4;

  assign in_board = (col_c >= ZERO) && (col_c <= COL_MAX)
                 && (row_c >= ZERO) && (row_c <= ROW_MAX);
  assign in_frame = (col_c >= NEG1) && (col_c <= COL_FR)
                 && (row_c >= NEG1) && (row_c <= ROW_FR);

  always_comb begin
    region_c = RG_BG;
    if (in_board)
      region_c = RG_BOARD;
    else if (in_frame)
      region_c = RG_FRAME;
  end

  assign addr_c = {3'b000, row_c[4:0]} * 8'd10
                + {4'b0000, col_c[3:0]};

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (piece_x[4*i +: 4] == col_q &&
          piece_y[5*i +: 5] == row_q)
        hit = 1'b1;
    end
    hit = hit & piece_valid;
  end

  cell_word_builder #(
    .BORDER_COLOR (BORDER_COLOR),
    .BG_COLOR     (BG_COLOR)
  ) u_builder (
    .region_i (region_q),
    .color_i  (color_q),
    .yoff_i   (yoff_q),
    .word_o   (word_c)
  );

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    col_d     = col_q;
    row_d     = row_q;
    yoff_d    = yoff_q;
    color_d   = color_q;
    staging_d = staging_q;
    pixels_d  = pixels_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (phase == 5'h1F)
          state_d = S_CALC;
      end
      S_CALC: begin
        region_d = region_c;
        col_d    = col_c[3:0];
        row_d    = row_c[4:0];
        yoff_d   = dy[3:0];
        if (region_c == RG_BOARD) begin
          addr_d  = addr_c;
          rd_en_d = 1'b1;
          state_d = S_ADDR;
        end else begin
          state_d = S_BUILD;
        end
      end
      S_ADDR: state_d = S_WAIT;
      S_WAIT: begin
        color_d = hit ? piece_color : ram.ram_data;
        state_d = S_BUILD;
      end
      S_BUILD: begin
        staging_d = word_c;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (phase == 5'h1E)
          pixels_d = staging_q;
        if (phase == 5'h1F)
          state_d = S_CALC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      region_q  <= RG_BG;
      col_q     <= '0;
      row_q     <= '0;
      yoff_q    <= '0;
      color_q   <= '0;
      staging_q <= '0;
      pixels_q  <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      col_q     <= col_d;
      row_q     <= row_d;
      yoff_q    <= yoff_d;
      color_q   <= color_d;
      staging_q <= staging_d;
      pixels_q  <= pixels_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
    end
  end

  assign ram.ram_addr  = addr_q;
  assign ram.ram_rd_en = rd_en_q;
  assign pixels        = pixels_q;

endmodule

// File: tb/tb_vga_board_fetch.sv
// Directed bench for vga_board_fetch with a board RAM model.
// Drives cnt_X/cnt_Y directly; checks pixels and RAM strobes.
module tb_vga_board_fetch;
  import tetris_vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] cnt_X;
  logic [9:0]  cnt_Y;
  logic        piece_valid;
  logic [15:0] piece_x;
  logic [19:0] piece_y;
  logic [2:0]  piece_color;
  logic [47:0] pixels;

  vga_board_fetch_if ram_bus ();

  logic [2:0] mem [0:199];
  int n_vec   = 0;
  int n_err   = 0;
  int n_pulse = 0;
  int p0;

  localparam logic [47:0] ONES = {16{3'b111}};

  vga_board_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .cnt_X       (cnt_X),
    .cnt_Y       (cnt_Y),
    .ram         (ram_bus),
    .piece_valid (piece_valid),
    .piece_x     (piece_x),
    .piece_y     (piece_y),
    .piece_color (piece_color),
    .pixels      (pixels)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (ram_bus.ram_rd_en) begin
      ram_bus.ram_data <= mem[ram_bus.ram_addr];
      n_pulse <= n_pulse + 1;
    end
  end

  function automatic logic [47:0] w15(input logic [2:0] c);
    return {3'b000, {15{c}}};
  endfunction

  task automatic chk(input string tag,
                     input logic [47:0] got,
                     input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // outputs afterwards reflect the edge ending cnt_X == to
  task automatic run(input int from, input int to,
                     input int y);
    for (int x = from; x <= to; x++) begin
      cnt_X = 11'(x);
      cnt_Y = 10'(y);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 200; i++) mem[i] = 3'b000;
    ram_bus.ram_data = 3'b000;
    rst = 1'b1;
    piece_valid = 1'b0;
    piece_x = '0;
    piece_y = '0;
    piece_color = '0;
    run(0, 0, 0);
    run(0, 0, 0);
    run(0, 0, 0);
    chk("rst_pix", pixels, '0);
    chk("rst_rd", 48'(ram_bus.ram_rd_en), '0);
    chk("rst_addr", 48'(ram_bus.ram_addr), '0);
    rst = 1'b0;

    // all-zero RAM: background, left frame, empty cell
    run(576, 660, 92);
    chk("bg_left", pixels, '0);
    run(661, 680, 92);
    chk("frame_left", pixels, ONES);
    run(681, 702, 92);
    chk("empty_cell", pixels, '0);
    run(703, 703, 92);

    // red cell at row 0 col 0
    mem[0] = CLR_RED;
    p0 = n_pulse;
    run(640, 671, 92);
    chk("rd_pre", 48'(ram_bus.ram_rd_en), '0);
    run(672, 672, 92);
    chk("rd_on", 48'(ram_bus.ram_rd_en), 48'd1);
    chk("rd_addr0", 48'(ram_bus.ram_addr), '0);
    run(673, 673, 92);
    chk("rd_off", 48'(ram_bus.ram_rd_en), '0);
    run(674, 701, 92);
    chk("held_old", pixels, ONES);
    run(702, 702, 92);
    chk("red_word", pixels, w15(CLR_RED));
    run(703, 703, 92);
    chk("red_hold", pixels, w15(CLR_RED));
    chk("one_pulse", 48'(n_pulse - p0), 48'd1);

    // last line of the cell is black
    run(640, 702, 107);
    chk("yoff15", pixels, '0);
    run(703, 703, 107);

    // overlay block 2 on (0,0) wins over RAM
    piece_valid = 1'b1;
    piece_x = {4'd5, 4'd0, 4'd5, 4'd5};
    piece_y = {5'd5, 5'd0, 5'd5, 5'd5};
    piece_color = CLR_GREEN;
    run(640, 702, 92);
    chk("ovl_hit", pixels, w15(CLR_GREEN));
    run(703, 703, 92);
    piece_x = {4'd5, 4'd1, 4'd5, 4'd5};
    run(640, 702, 92);
    chk("ovl_miss", pixels, w15(CLR_RED));
    run(703, 703, 92);
    piece_valid = 1'b0;

    // bottom-right cell, then right frame
    mem[199] = CLR_BLUE;
    run(928, 960, 400);
    chk("br_rd", 48'(ram_bus.ram_rd_en), 48'd1);
    chk("br_addr", 48'(ram_bus.ram_addr), 48'd199);
    run(961, 990, 400);
    chk("br_word", pixels, w15(CLR_BLUE));
    run(991, 1022, 400);
    chk("frame_right", pixels, ONES);
    run(1023, 1023, 400);

    // top frame row and below-frame background
    run(768, 798, 80);
    chk("frame_top", pixels, ONES);
    run(799, 799, 80);
    run(768, 798, 428);
    chk("below_bg", pixels, '0);
    run(799, 799, 428);

    // reset in the middle of a word
    mem[1] = 3'b011;
    run(640, 689, 92);
    rst = 1'b1;
    run(690, 690, 92);
    rst = 1'b0;
    chk("rst_mid", pixels, '0);
    p0 = n_pulse;
    run(691, 702, 92);
    chk("rst_drop", pixels, '0);
    run(703, 703, 92);
    chk("rst_idle", 48'(n_pulse - p0), '0);
    run(704, 733, 92);
    chk("rst_wait", pixels, '0);
    run(734, 734, 92);
    chk("rst_resume", pixels, w15(3'b011));
    run(735, 735, 92);

    // end of line and wrap to word 0
    run(1568, 1598, 92);
    chk("wrap50", pixels, '0);
    run(1599, 1599, 92);
    run(0, 30, 92);
    chk("wrap1", pixels, '0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
